ebc_event_packetizer: RTL and testbench
=======================================

Name: ebc_event_packetizer

Overview:
- Downstream stage of the x/y round-robin arbiters in the event-based camera readout.
- Each cycle, captures the granted column/row addresses and the group-release flag, stamps them with a free-running timestamp, and buffers the resulting packet in a small FIFO.
- Drains packets on a valid/ready stream toward the output link.
- Drives a stall signal back to the arbiters' enable so no grant is produced while the FIFO cannot accept it.

Parameters:
- X_AW, 2, column address width (matches x arbiter add_o).
- Y_AW, 2, row address width.
- TS_W, 16, timestamp counter width.
- DEPTH, 8, FIFO entries; power of two, >= 4.
- AFULL_TH, 2, free-slot count at or below which stall_o asserts; 1 <= AFULL_TH < DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- evt_valid_i  in  1  arbiter produced a grant this cycle.
- x_add_i  in  X_AW  granted column address.
- y_add_i  in  Y_AW  granted row address.
- grp_release_i  in  1  x arbiter group release, captured as packet "last" bit.
- flush_i  in  1  synchronous FIFO clear.
- stall_o  out  1  backpressure; arbiter enable = !stall_o.
- m_valid_o  out  1  packet available.
- m_ready_i  in  1  consumer accepts packet.
- m_data_o  out  PKT_W  packet {ts, last, y, x}.
- drop_cnt_o  out  8  saturating count of dropped events.
- ovf_o  out  1  sticky overflow flag.
- ts_wrap_o  out  1  one-cycle pulse when the timestamp wraps.

Behaviour:
- PKT_W = TS_W + 1 + Y_AW + X_AW with the timestamp feature; 1 + Y_AW + X_AW without it.
- Reset (reset_n low, async):
  - ts = 0; pointers = 0; count = 0.
  - m_valid_o = 0, m_data_o = 0, stall_o = 0, drop_cnt_o = 0, ovf_o = 0, ts_wrap_o = 0.
  - Release is synchronous to clk.
- Timestamp:
  - ts increments every cycle, modulo 2^TS_W.
  - ts_wrap_o is registered, high for the cycle in which ts reads 0 after holding all-ones.
  - Packets carry the ts value in the capture cycle.
- Push: evt_valid_i high and (count < DEPTH, or a pop occurs in the same cycle) -> write {ts, grp_release_i, y_add_i, x_add_i} at wr_ptr.
- Pop: m_valid_o and m_ready_i both high -> rd_ptr advances.
- Pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
- Push and pop in the same cycle: count unchanged, both pointers advance. Also legal when full.
- Empty with push and m_ready_i high in the same cycle: no fall-through; the packet appears the next cycle.
- Output: show-ahead.
  - m_valid_o = (count != 0).
  - m_data_o = mem[rd_ptr], registered, valid the cycle after the write.
  - Push-to-m_valid_o latency is 1 cycle.
  - m_data_o holds stable while m_valid_o && !m_ready_i.
- stall_o = (DEPTH - count) <= AFULL_TH, combinational from the count register.
- Drop: push attempted while full with no pop -> event discarded, drop_cnt_o += 1 (saturating at 255), ovf_o set.
- flush_i, with priority over push/pop in the same cycle:
  - pointers and count -> 0; drop_cnt_o and ovf_o cleared; m_valid_o = 0 next cycle.
  - ts is not cleared.
- Address inputs are ignored when evt_valid_i is low.
- Reset mid-stream: all FIFO contents lost, no partial packet emitted.

Optional Feature:
- Macro: EBC_TIMESTAMP_EN.
- Defined: timestamp counter present, packet includes the ts field, ts_wrap_o driven as above.
- Undefined: no counter; PKT_W excludes TS_W; ts_wrap_o tied 0. TS_W is still accepted but unused.

Decomposition:
- Shared package ebc_pkg:
  - X_AW/Y_AW/TS_W defaults.
  - PKT_W function.
  - packed struct typedef evt_pkt_t {ts, last, y, x}, with the ts member under the macro.
  - DROP_CNT_W = 8.
- One sub-module, ebc_sync_fifo: parameterised DEPTH/width, push/pop, count, full/empty, flush.
- The packetizer wraps ebc_sync_fifo with the timestamp counter, drop/ovf logic and stall generation.

Test Plan:
- Reset then 3 events (x=1,y=2), (x=3,y=0,last=1), (x=0,y=3), m_ready_i=1 -> three packets in order, each 1 cycle after push, ts values N, N+1, N+2, last bit only on the 2nd.
- m_ready_i=0, 8 consecutive events, DEPTH=8, AFULL_TH=2 -> stall_o rises after the 6th push; 9th and 10th events dropped, drop_cnt_o=2, ovf_o=1, FIFO holds the first 8 unchanged.
- Full FIFO, then push and pop in the same cycle -> no drop, count stays 8, popped packet is the oldest, new packet is at the tail.
- 300 forced drops -> drop_cnt_o saturates at 255; flush_i pulse -> drop_cnt_o=0, ovf_o=0, m_valid_o=0 next cycle, ts unaffected.
- Run 65536 cycles with EBC_TIMESTAMP_EN -> single ts_wrap_o pulse and an event packet carrying ts=0 after the wrap; rebuild without the macro -> PKT_W = 5, ts_wrap_o constant 0.
- reset_n asserted asynchronously mid-cycle with 4 entries queued -> outputs go to reset values immediately, no packet emitted after release.

Source files
------------

// File: rtl/ebc_pkg.sv
// Shared types and constants for the event-based camera packetizer.
// EBC_TIMESTAMP_EN adds the timestamp field to every packet.
package ebc_pkg;

  localparam int X_AW_DEF   = 2;
  localparam int Y_AW_DEF   = 2;
  localparam int TS_W_DEF   = 16;
  localparam int DROP_CNT_W = 8;

`ifdef EBC_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  function automatic int pkt_w(input int x_aw, input int y_aw, input int ts_w);
    return (TS_EN ? ts_w : 0) + 1 + y_aw + x_aw;
  endfunction

  typedef struct packed {
`ifdef EBC_TIMESTAMP_EN
    logic [TS_W_DEF-1:0] ts;
`endif
    logic                last;
    logic [Y_AW_DEF-1:0] y;
    logic [X_AW_DEF-1:0] x;
  } evt_pkt_t;

endpackage

// File: rtl/ebc_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word, simultaneous
// push/pop when full, and a synchronous flush.
module ebc_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             wr_en, rd_en;

  assign valid_o  = (count_q != '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign rd_en    = pop_i && valid_o;
  assign wr_en    = push_i && (!full_o || rd_en);
  assign rd_ptr_d = rd_ptr_q + AW'(rd_en);

  // The head register bypasses the write data when the new head slot is
  // being written this very cycle (empty, or one entry being replaced).
  always_comb begin
    rdata_d = mem_q[rd_ptr_d];
    if (wr_en && (wr_ptr_q == rd_ptr_d)) rdata_d = wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_q + CW'(wr_en) - CW'(rd_en);
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers and count, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = rdata_q;
  assign count_o = count_q;

endmodule

// File: rtl/ebc_event_packetizer.sv
// Stamps arbiter grants into packets, buffers them and streams them out.
// EBC_TIMESTAMP_EN enables the free-running timestamp and its wrap pulse.
module ebc_event_packetizer
  import ebc_pkg::*;
#(
  parameter  int X_AW     = X_AW_DEF,
  parameter  int Y_AW     = Y_AW_DEF,
  parameter  int TS_W     = TS_W_DEF,
  parameter  int DEPTH    = 8,
  parameter  int AFULL_TH = 2,
  localparam int PKT_W    = pkt_w(X_AW, Y_AW, TS_W)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  evt_valid_i,
  input  logic [X_AW-1:0]       x_add_i,
  input  logic [Y_AW-1:0]       y_add_i,
  input  logic                  grp_release_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [PKT_W-1:0]      m_data_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  output logic                  ovf_o,
  output logic                  ts_wrap_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, pop, drop;
  logic [PKT_W-1:0]      pkt;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  ovf_q, ovf_d;

`ifdef EBC_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic            ts_wrap_q;

  // Free-running; flush leaves it alone so packet times stay monotonic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q      <= '0;
      ts_wrap_q <= 1'b0;
    end else begin
      ts_q      <= ts_q + TS_W'(1);
      ts_wrap_q <= &ts_q;
    end
  end

  assign pkt       = {ts_q, grp_release_i, y_add_i, x_add_i};
  assign ts_wrap_o = ts_wrap_q;
`else
  assign pkt       = {grp_release_i, y_add_i, x_add_i};
  assign ts_wrap_o = 1'b0;
`endif

  assign pop  = m_valid_o && m_ready_i;
  assign drop = evt_valid_i && fifo_full && !pop;

  ebc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (evt_valid_i),
    .wdata_i (pkt),
    .pop_i   (m_ready_i),
    .flush_i (flush_i),
    .rdata_o (m_data_o),
    .valid_o (m_valid_o),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // NOTE: defaults are assigned first so no path leaves a variable
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (flush_i) begin
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Asserted early enough that grants already in flight still fit.
  assign stall_o    = (CW'(DEPTH) - fifo_count) <= CW'(AFULL_TH);
  assign drop_cnt_o = drop_cnt_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_ebc_event_packetizer.sv
// Scoreboard bench for ebc_event_packetizer: a cycle model predicts
// occupancy, drops and packet contents; directed checks cover boundaries.
module tb_ebc_event_packetizer;
  import ebc_pkg::*;

  localparam int DEPTH    = 8;
  localparam int AFULL_TH = 2;
  localparam int PKT_W    = pkt_w(X_AW_DEF, Y_AW_DEF, TS_W_DEF);

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  evt_valid_i = 1'b0;
  logic [X_AW_DEF-1:0]   x_add_i = '0;
  logic [Y_AW_DEF-1:0]   y_add_i = '0;
  logic                  grp_release_i = 1'b0;
  logic                  flush_i = 1'b0;
  logic                  m_ready_i = 1'b0;
  logic                  stall_o, m_valid_o, ovf_o, ts_wrap_o;
  logic [PKT_W-1:0]      m_data_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ebc_event_packetizer #(
    .X_AW     (X_AW_DEF),
    .Y_AW     (Y_AW_DEF),
    .TS_W     (TS_W_DEF),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .evt_valid_i   (evt_valid_i),
    .x_add_i       (x_add_i),
    .y_add_i       (y_add_i),
    .grp_release_i (grp_release_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .drop_cnt_o    (drop_cnt_o),
    .ovf_o         (ovf_o),
    .ts_wrap_o     (ts_wrap_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference timestamp: counts cycles since reset release.
  logic [TS_W_DEF-1:0] tb_ts;
  logic                exp_wrap;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tb_ts    <= '0;
      exp_wrap <= 1'b0;
    end else begin
      tb_ts <= tb_ts + 16'd1;
`ifdef EBC_TIMESTAMP_EN
      exp_wrap <= (tb_ts == 16'hFFFF);
`endif
    end
  end

  // Scoreboard: sampled mid low phase, then updated for the coming edge.
  logic [PKT_W-1:0]      exp_q [$];
  logic [DROP_CNT_W-1:0] m_drop = '0;
  logic                  m_ovf = 1'b0;
  int                    wrap_seen = 0;
  evt_pkt_t              mdl_pkt;
  bit                    mdl_pop, mdl_full;

  always @(negedge clk) begin
    #2;
    if (!reset_n) begin
      exp_q.delete();
      m_drop = '0;
      m_ovf  = 1'b0;
    end else begin
      check("m_valid", m_valid_o, exp_q.size() != 0);
      check("stall", stall_o, (DEPTH - exp_q.size()) <= AFULL_TH);
      if (exp_q.size() != 0) check("m_data", m_data_o, exp_q[0]);
      check("drop_cnt", drop_cnt_o, m_drop);
      check("ovf", ovf_o, m_ovf);
      check("ts_wrap", ts_wrap_o, exp_wrap);
      if (ts_wrap_o) wrap_seen++;
      if (flush_i) begin
        exp_q.delete();
        m_drop = '0;
        m_ovf  = 1'b0;
      end else begin
        mdl_pop  = (exp_q.size() != 0) && m_ready_i;
        mdl_full = (exp_q.size() == DEPTH);
        if (mdl_pop) void'(exp_q.pop_front());
        if (evt_valid_i) begin
          if (!mdl_full || mdl_pop) begin
            mdl_pkt.x    = x_add_i;
            mdl_pkt.y    = y_add_i;
            mdl_pkt.last = grp_release_i;
`ifdef EBC_TIMESTAMP_EN
            mdl_pkt.ts   = tb_ts;
`endif
            exp_q.push_back(mdl_pkt);
          end else begin
            m_ovf = 1'b1;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic [X_AW_DEF-1:0] x, input logic [Y_AW_DEF-1:0] y,
                      input logic l, input logic rdy, input logic fl);
    @(negedge clk);
    evt_valid_i   = v;
    x_add_i       = x;
    y_add_i       = y;
    grp_release_i = l;
    m_ready_i     = rdy;
    flush_i       = fl;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  bit found;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", m_valid_o, 0);
    check("rst_m_data", m_data_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_wrap", ts_wrap_o, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Three events streamed straight through.
    step(1'b1, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Fill while blocked: ten events, the last two dropped.
    for (int i = 0; i < 10; i++) step(1'b1, 2'(i), 2'(i >> 2), i[0], 1'b0, 1'b0);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("fill_drop", drop_cnt_o, 2);
    check("fill_ovf", ovf_o, 1);
    check("fill_stall", stall_o, 1);

    // Push and pop together while full, then drain.
    step(1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("pp_drop", drop_cnt_o, 2);
    check("pp_stall", stall_o, 1);
    repeat (9) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("drained", m_valid_o, 0);

    // Saturate the drop counter, then flush with a competing event.
    for (int i = 0; i < 308; i++) step(1'b1, 2'(i), 2'(i >> 3), 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("sat_drop", drop_cnt_o, 255);
    step(1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("flush_valid", m_valid_o, 0);
    check("flush_drop", drop_cnt_o, 0);
    check("flush_ovf", ovf_o, 0);
    step(1'b1, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with four entries queued.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 2'(3 - i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_valid", m_valid_o, 0);
    check("arst_data", m_data_o, 0);
    check("arst_stall", stall_o, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

`ifdef EBC_TIMESTAMP_EN
    found = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (tb_ts == 16'hFFFF) begin
        found = 1'b1;
        break;
      end
    end
    check("wrap_wait", found, 1);
    step(1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("wrap_pkt_valid", m_valid_o, 1);
    check("wrap_pkt_ts", m_data_o[PKT_W-1 -: TS_W_DEF], 0);
    repeat (3) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    check("wrap_pulses", wrap_seen, 1);
`else
    found = 1'b0;
    step(1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
    repeat (2000) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    check("wrap_pulses", wrap_seen, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
